// File: rtl/motoro3_gate_monitor.sv
// Receive-side monitor for the six three-phase gate drive lines.
// Samples the gates, filters short patterns, decodes the six-step
// commutation sequence and reports step, direction, period and faults.
module motoro3_gate_monitor #(
  parameter int MIN_DWELL = 4,
  parameter int CNT_W     = 24,
  parameter int TIMEOUT   = 5000000
) (
  input  logic             clk50mhz,
  input  logic             reset,
  input  logic             aH,
  input  logic             aL,
  input  logic             bH,
  input  logic             bL,
  input  logic             cH,
  input  logic             cL,
  input  logic             faultClr,
  output logic [2:0]       mState,
  output logic             mRunning,
  output logic             mDir,
  output logic             stepStrobe,
  output logic [CNT_W-1:0] stepPeriod,
  output logic [15:0]      stepCount,
  output logic             faultShoot,
  output logic             faultSeq
);

  typedef enum logic [1:0] {ST_IDLE, ST_FIRST, ST_RUN} state_t;

  localparam logic [7:0]       LP_DWELL = 8'(MIN_DWELL);
  localparam logic [CNT_W-1:0] LP_TMO   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LP_MAX   = '1;

  logic [5:0]       w_gates;
  logic [5:0]       r_s;
  logic [5:0]       r_acc;
  logic [7:0]       r_dwell;
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_period;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic             r_run;
  logic             w_run_nxt;
  logic             r_strobe;
  logic             w_step_upd;
  logic             w_seq_set;
  logic [15:0]      r_cnt;
  logic             r_fshoot;
  logic             r_fseq;
  logic             w_accept;
  logic             w_shoot;
  logic             w_valid;
  logic             w_idle;
  logic             w_fwd;
  logic             w_rev;
  logic [2:0]       w_k;

  // Bit order: {cL, cH, bL, bH, aL, aH}, i.e. phase p owns bits 2p (H) and 2p+1 (L).
  assign w_gates = {cL, cH, bL, bH, aL, aH};

  // Decode the sampled pattern into a step index; anything unlisted is illegal.
  always_comb begin
    w_valid = 1'b1;
    w_k     = 3'd0;
    case (r_s)
      6'b001001: w_k = 3'd0;  // AH+BL
      6'b100001: w_k = 3'd1;  // AH+CL
      6'b100100: w_k = 3'd2;  // BH+CL
      6'b000110: w_k = 3'd3;  // BH+AL
      6'b010010: w_k = 3'd4;  // CH+AL
      6'b011000: w_k = 3'd5;  // CH+BL
      default:   w_valid = 1'b0;
    endcase
  end

  assign w_idle   = (r_s == 6'd0);
  assign w_shoot  = (r_s[0] & r_s[1]) | (r_s[2] & r_s[3]) | (r_s[4] & r_s[5]);
  // Accept one edge after the dwell counter saturates, only for a new pattern.
  assign w_accept = (r_dwell == LP_DWELL) && (r_s != r_acc);
  // Adjacency against the accepted index (meaningless while idle, never used then).
  assign w_fwd    = (w_k == ((r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1));
  assign w_rev    = (w_k == ((r_idx == 3'd0) ? 3'd5 : r_idx - 3'd1));

  // Gate sampling and dwell filter: count consecutive identical samples.
  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      r_s     <= '0;
      r_dwell <= '0;
      r_acc   <= '0;
    end else begin
      r_s <= w_gates;
      if (w_gates != r_s)          r_dwell <= '0;
      else if (r_dwell != LP_DWELL) r_dwell <= r_dwell + 8'd1;
      if (w_accept) r_acc <= r_s;
    end
  end

  // Period counter: clocks since the last accept edge, saturating.
  always_ff @(posedge clk50mhz) begin
    if (reset)               r_per <= '0;
    else if (w_accept)       r_per <= CNT_W'(1);
    else if (r_per != LP_MAX) r_per <= r_per + CNT_W'(1);
  end

  // State register plus the registered status it drives.
  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= 3'd7;
      r_dir    <= 1'b0;
      r_run    <= 1'b0;
      r_strobe <= 1'b0;
      r_period <= '0;
      r_cnt    <= '0;
      r_fshoot <= 1'b0;
      r_fseq   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_dir    <= w_dir_nxt;
      r_run    <= w_run_nxt;
      r_strobe <= w_step_upd;
      if (w_step_upd) begin
        r_period <= r_per;
        r_cnt    <= r_cnt + 16'd1;
      end
      // A new fault in the same cycle as a clear keeps the flag set.
      r_fshoot <= w_shoot   | (r_fshoot & ~faultClr);
      r_fseq   <= w_seq_set | (r_fseq   & ~faultClr);
    end
  end

  // Next-state: react to accepted patterns, else watch for a stalled run.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_dir_nxt   = r_dir;
    w_run_nxt   = r_run;
    w_step_upd  = 1'b0;
    w_seq_set   = 1'b0;
    if (w_accept) begin
      if (w_idle || !w_valid) begin
        w_seq_set   = !w_idle;
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = 3'd7;
        w_run_nxt   = 1'b0;
      end else begin
        w_idx_nxt = w_k;
        if (r_state == ST_IDLE) begin
          w_state_nxt = ST_FIRST;
        end else begin
          w_step_upd = 1'b1;
          if (r_state == ST_FIRST) begin
            if (w_fwd || w_rev) begin
              w_state_nxt = ST_RUN;
              w_dir_nxt   = w_rev;
            end else begin
              w_seq_set   = 1'b1;
              w_state_nxt = ST_FIRST;
            end
          end else if ((w_fwd && !r_dir) || (w_rev && r_dir)) begin
            w_run_nxt = 1'b1;
          end else begin
            // Reversal restarts direction detection; a jump is a fault.
            w_seq_set   = !(w_fwd || w_rev);
            w_dir_nxt   = (w_fwd || w_rev) ? ~r_dir : r_dir;
            w_run_nxt   = 1'b0;
            w_state_nxt = ST_FIRST;
          end
        end
      end
    end else if (r_state == ST_RUN && r_per == LP_TMO) begin
      w_run_nxt   = 1'b0;
      w_state_nxt = ST_FIRST;
    end
  end

  // Outputs straight from registers.
  always_comb begin
    mState     = r_idx;
    mRunning   = r_run;
    mDir       = r_dir;
    stepStrobe = r_strobe;
    stepPeriod = r_period;
    stepCount  = r_cnt;
    faultShoot = r_fshoot;
    faultSeq   = r_fseq;
  end

endmodule

// File: tb/tb_motoro3_gate_monitor.sv
// Bench for motoro3_gate_monitor: directed scenarios plus random gate streams,
// checked cycle by cycle against an event-level reference model.
module tb_motoro3_gate_monitor;

  localparam int MIN_DWELL = 4;
  localparam int CNT_W     = 24;
  localparam int TIMEOUT   = 1000;

  logic clk50mhz = 1'b0;
  logic reset = 1'b0;
  logic aH = 1'b0, aL = 1'b0, bH = 1'b0, bL = 1'b0, cH = 1'b0, cL = 1'b0;
  logic faultClr = 1'b0;
  logic [2:0]       mState;
  logic             mRunning, mDir, stepStrobe, faultShoot, faultSeq;
  logic [CNT_W-1:0] stepPeriod;
  logic [15:0]      stepCount;

  always #10 clk50mhz = ~clk50mhz;

  motoro3_gate_monitor #(.MIN_DWELL(MIN_DWELL), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk50mhz(clk50mhz), .reset(reset),
    .aH(aH), .aL(aL), .bH(bH), .bL(bL), .cH(cH), .cL(cL),
    .faultClr(faultClr),
    .mState(mState), .mRunning(mRunning), .mDir(mDir), .stepStrobe(stepStrobe),
    .stepPeriod(stepPeriod), .stepCount(stepCount),
    .faultShoot(faultShoot), .faultSeq(faultSeq)
  );

  int ntests = 0;
  int nfail  = 0;

  // Step table by phase (a=0, b=1, c=2): high-side phase and low-side phase.
  int hiPh [6] = '{0, 0, 1, 1, 2, 2};
  int loPh [6] = '{1, 2, 2, 0, 0, 1};

  // Reference model state
  logic [5:0] m_pat, m_acc;
  int m_run, m_idx, m_period, m_count, m_cyc = 0, m_last;
  bit m_known, m_dir, m_running, m_strobe, m_fsh, m_fsq;

  function automatic logic [5:0] stepPat(input int k);
    logic [5:0] p;
    p = '0;
    p[2*hiPh[k]]   = 1'b1;
    p[2*loPh[k]+1] = 1'b1;
    return p;
  endfunction

  function automatic int decodeStep(input logic [5:0] g);
    for (int k = 0; k < 6; k++) if (g == stepPat(k)) return k;
    return -1;
  endfunction

  function automatic logic [47:0] obs();
    return {mState, mRunning, mDir, stepStrobe, stepPeriod, stepCount, faultShoot, faultSeq};
  endfunction

  function automatic logic [47:0] expv();
    return {3'(m_idx), m_running, m_dir, m_strobe, CNT_W'(m_period), 16'(m_count), m_fsh, m_fsq};
  endfunction

  // One clock edge of the model: the sampled pattern (m_pat) and how many edges
  // it has been seen decide acceptance; the accepted step is judged by mod-6 distance.
  task automatic model_edge(input logic [5:0] g, input bit clr, input bit rst);
    bit shoot, seq;
    int k, d, want;
    m_cyc++;
    if (rst) begin
      m_pat = '0; m_run = 1; m_acc = '0; m_idx = 7; m_known = 0; m_dir = 0;
      m_running = 0; m_strobe = 0; m_period = 0; m_count = 0;
      m_fsh = 0; m_fsq = 0; m_last = m_cyc;
      return;
    end
    shoot = 0;
    for (int ph = 0; ph < 3; ph++) if (m_pat[2*ph] && m_pat[2*ph+1]) shoot = 1;
    seq = 0;
    m_strobe = 0;
    if (m_run > MIN_DWELL && m_pat != m_acc) begin
      m_acc = m_pat;
      k = decodeStep(m_pat);
      if (m_pat == 6'd0) begin
        m_idx = 7; m_running = 0; m_known = 0;
      end else if (k < 0) begin
        seq = 1; m_idx = 7; m_running = 0; m_known = 0;
      end else if (m_idx == 7) begin
        m_idx = k; m_known = 0;
      end else begin
        d = (k - m_idx + 6) % 6;
        m_period = m_cyc - m_last;
        m_strobe = 1;
        m_count  = (m_count + 1) % 65536;
        if (!m_known) begin
          if (d == 1)      begin m_known = 1; m_dir = 0; end
          else if (d == 5) begin m_known = 1; m_dir = 1; end
          else seq = 1;
        end else begin
          want = m_dir ? 5 : 1;
          if (d == want) m_running = 1;
          else if (d == 6 - want) begin m_dir = !m_dir; m_running = 0; m_known = 0; end
          else begin seq = 1; m_running = 0; m_known = 0; end
        end
        m_idx = k;
      end
      m_last = m_cyc;
    end else if (m_known && (m_cyc - m_last) == TIMEOUT) begin
      m_running = 0; m_known = 0;
    end
    m_fsh = shoot || (m_fsh && !clr);
    m_fsq = seq   || (m_fsq && !clr);
    if (g == m_pat) begin
      if (m_run < 1000000) m_run++;
    end else begin
      m_pat = g; m_run = 1;
    end
  endtask

  // Drive one cycle of inputs, step the model on the edge, return at negedge.
  task automatic cyc(input logic [5:0] g, input bit clr, input bit rst);
    {cL, cH, bL, bH, aL, aH} = g;
    faultClr = clr;
    reset    = rst;
    @(posedge clk50mhz);
    model_edge(g, clr, rst);
    @(negedge clk50mhz);
  endtask

  task automatic test_reset();
    cyc(6'd0, 0, 1);
    cyc(6'd0, 0, 1);
    ntests++;
    if (obs() !== {3'd7, 45'd0}) begin
      nfail++; $display("FAIL reset_values: got %h want %h", obs(), {3'd7, 45'd0});
    end
    for (int c = 0; c < 10; c++) begin
      cyc(6'd0, 0, 0);
      ntests++;
      if (obs() !== {3'd7, 45'd0}) begin
        nfail++; $display("FAIL reset_idle c%0d: got %h want %h", c, obs(), {3'd7, 45'd0});
      end
    end
  endtask

  task automatic test_forward();
    int strobes = 0;
    cyc(6'd0, 0, 1);
    for (int s = 0; s < 7; s++) begin
      for (int c = 0; c < 100; c++) begin
        cyc(stepPat(s % 6), 0, 0);
        strobes += int'(stepStrobe);
        ntests++;
        if (obs() !== expv()) begin
          nfail++; $display("FAIL fwd s%0d c%0d: got %h want %h", s, c, obs(), expv());
        end
      end
      ntests++;
      if (mRunning !== (s >= 2)) begin
        nfail++; $display("FAIL fwd_running s%0d: got %b want %b", s, mRunning, (s >= 2));
      end
    end
    ntests++;
    if (strobes != 6 || stepCount !== 16'd6 || stepPeriod !== CNT_W'(100) || mDir !== 1'b0) begin
      nfail++;
      $display("FAIL fwd_totals: got strobes=%0d count=%0d period=%0d dir=%b want 6 6 100 0",
               strobes, stepCount, stepPeriod, mDir);
    end
  endtask

  task automatic test_glitch();
    logic [5:0] g;
    cyc(6'd0, 0, 1);
    for (int c = 0; c < 100; c++) cyc(stepPat(0), 0, 0);
    for (int c = 0; c < 100; c++) begin
      g = (c >= 40 && c < 43) ? stepPat(3) : stepPat(1);
      cyc(g, 0, 0);
      ntests++;
      if (obs() !== expv()) begin
        nfail++; $display("FAIL glitch c%0d: got %h want %h", c, obs(), expv());
      end
    end
    for (int c = 0; c < 20; c++) begin
      cyc(stepPat(2), 0, 0);
      // New pattern sampled on the first edge, visible MIN_DWELL+1 edges later.
      if (c == MIN_DWELL || c == MIN_DWELL + 1) begin
        ntests++;
        if (mState !== ((c == MIN_DWELL) ? 3'd1 : 3'd2)) begin
          nfail++; $display("FAIL glitch_latency c%0d: got %0d want %0d", c, mState,
                            (c == MIN_DWELL) ? 1 : 2);
        end
      end
    end
    ntests++;
    if (faultSeq !== 1'b0 || stepPeriod !== CNT_W'(100) || mRunning !== 1'b1) begin
      nfail++; $display("FAIL glitch_end: got seq=%b period=%0d run=%b want 0 100 1",
                        faultSeq, stepPeriod, mRunning);
    end
  endtask

  task automatic test_shoot();
    logic [5:0] tg [11] = '{0, 0, 0, 3, 0, 0, 0, 0, 3, 0, 0};
    bit         tc [11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    bit         te [11] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
    cyc(6'd0, 0, 1);
    for (int i = 0; i < 11; i++) begin
      cyc(tg[i], tc[i], 0);
      ntests++;
      if (faultShoot !== te[i] || faultSeq !== 1'b0) begin
        nfail++; $display("FAIL shoot i%0d: got shoot=%b seq=%b want %b 0", i, faultShoot, faultSeq, te[i]);
      end
    end
  endtask

  task automatic test_seq_reverse();
    int st   [8] = '{4, 5, 0, 3, 7, 5, 4, 3};
    bit erun [8] = '{0, 0, 1, 0, 0, 0, 0, 1};
    bit eseq [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
    logic [5:0] g;
    cyc(6'd0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      g = (st[i] == 7) ? 6'd0 : stepPat(st[i]);
      for (int c = 0; c < 20; c++) begin
        cyc(g, 0, 0);
        ntests++;
        if (obs() !== expv()) begin
          nfail++; $display("FAIL seq i%0d c%0d: got %h want %h", i, c, obs(), expv());
        end
      end
      ntests++;
      if (mRunning !== erun[i] || faultSeq !== eseq[i] || mState !== 3'(st[i])) begin
        nfail++; $display("FAIL seq_end i%0d: got run=%b seq=%b st=%0d want %b %b %0d",
                          i, mRunning, faultSeq, mState, erun[i], eseq[i], st[i]);
      end
    end
    ntests++;
    if (mDir !== 1'b1) begin
      nfail++; $display("FAIL reverse_dir: got %b want 1", mDir);
    end
  endtask

  task automatic test_timeout_reset();
    cyc(6'd0, 0, 1);
    for (int s = 0; s < 2; s++) for (int c = 0; c < 30; c++) cyc(stepPat(s), 0, 0);
    for (int c = 0; c < 1100; c++) begin
      cyc(stepPat(2), 0, 0);
      ntests++;
      if (obs() !== expv()) begin
        nfail++; $display("FAIL timeout c%0d: got %h want %h", c, obs(), expv());
      end
      // Step 2 accepted at c == MIN_DWELL+1; drop exactly TIMEOUT edges later.
      if (c == MIN_DWELL + TIMEOUT || c == MIN_DWELL + 1 + TIMEOUT) begin
        ntests++;
        if (mRunning !== (c == MIN_DWELL + TIMEOUT)) begin
          nfail++; $display("FAIL timeout_edge c%0d: got %b want %b", c, mRunning,
                            (c == MIN_DWELL + TIMEOUT));
        end
      end
    end
    for (int c = 0; c < 30; c++) cyc(stepPat(3), 0, 0);
    ntests++;
    if (mRunning !== 1'b0 || faultSeq !== 1'b0 || stepPeriod !== CNT_W'(1100) || mState !== 3'd3) begin
      nfail++; $display("FAIL timeout_restart: got run=%b seq=%b period=%0d st=%0d want 0 0 1100 3",
                        mRunning, faultSeq, stepPeriod, mState);
    end
    for (int c = 0; c < 30; c++) cyc(stepPat(4), 0, 0);
    ntests++;
    if (mRunning !== 1'b1) begin
      nfail++; $display("FAIL timeout_rerun: got %b want 1", mRunning);
    end
    cyc(stepPat(4), 0, 1);
    ntests++;
    if (obs() !== {3'd7, 45'd0}) begin
      nfail++; $display("FAIL midrun_reset: got %h want %h", obs(), {3'd7, 45'd0});
    end
    for (int c = 0; c < 15; c++) begin
      cyc(stepPat(4), 0, 0);
      ntests++;
      if (obs() !== expv()) begin
        nfail++; $display("FAIL post_reset c%0d: got %h want %h", c, obs(), expv());
      end
    end
    ntests++;
    if (mState !== 3'd4 || mRunning !== 1'b0) begin
      nfail++; $display("FAIL post_reset_state: got st=%0d run=%b want 4 0", mState, mRunning);
    end
  endtask

  task automatic test_random();
    int cur = 0;
    int n, r;
    logic [5:0] g;
    cyc(6'd0, 0, 1);
    for (int seg = 0; seg < 300; seg++) begin
      r = $urandom_range(99);
      if (r < 55) begin
        cur = (cur + (($urandom_range(1) == 1) ? 1 : 5)) % 6;
        g = stepPat(cur); n = $urandom_range(30, 3);
      end else if (r < 65) begin
        cur = $urandom_range(5); g = stepPat(cur); n = $urandom_range(30, 3);
      end else if (r < 72) begin
        g = 6'd0; n = $urandom_range(20, 1);
      end else if (r < 80) begin
        g = 6'($urandom_range(63)); n = $urandom_range(12, 1);
      end else if (r < 97) begin
        g = stepPat($urandom_range(5)); n = $urandom_range(MIN_DWELL + 1, 1);
      end else begin
        cur = (cur + 1) % 6; g = stepPat(cur); n = TIMEOUT + $urandom_range(50);
      end
      for (int c = 0; c < n; c++) begin
        cyc(g, ($urandom_range(99) < 3), ($urandom_range(1999) == 0));
        ntests++;
        if (obs() !== expv()) begin
          nfail++; $display("FAIL random seg%0d c%0d: got %h want %h", seg, c, obs(), expv());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_glitch();
    test_shoot();
    test_seq_reverse();
    test_timeout_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
